fp_expr_seq: RTL

- Parametrised successor to the fixed-chain float expression evaluator.
- Computes y = A*x + x^2 * cos((x - C) * K) on IEEE-754 single-precision inputs. A, C and K are parameters.
- Drives one shared multiplier, one shared adder/subtractor and one float-in/float-out cosine unit through start/done ports. Operator instances sit outside this block.
- Adds an input FIFO, valid/ready handshakes on both sides, and operand-level parallel issue.

---
 rtl/fp_expr_seq.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_expr_seq.sv
// Sequencer for y = A*x + x^2 * cos((x - C) * K) over shared external mul/add/cos units.
// Optional per-wait watchdog is compiled in with FP_EXPR_SEQ_TIMEOUT_EN.
module fp_expr_seq #(
  parameter logic [31:0] COEF_A         = 32'h3F000000,
  parameter logic [31:0] OFFSET_C       = 32'h43000000,
  parameter logic [31:0] SCALE_K        = 32'h3C000000,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        err,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [31:0] mul_result,
  output logic        add_start,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_sub,
  input  logic        add_done,
  input  logic [31:0] add_result,
  output logic        cos_start,
  output logic [31:0] cos_arg,
  input  logic        cos_done,
  input  logic [31:0] cos_result
);

  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
  localparam logic [31:0] QNAN      = 32'h7FC00000;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_1    = 3'd1;
  localparam logic [2:0] S_2    = 3'd2;
  localparam logic [2:0] S_3    = 3'd3;
  localparam logic [2:0] S_4    = 3'd4;
  localparam logic [2:0] S_5    = 3'd5;
  localparam logic [2:0] S_OUT  = 3'd6;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          in_ready_reg;
  logic          push, pop;

  logic [2:0]  state_reg, state_next;
  logic        first_reg, first_next;
  logic        mul_pend_reg, add_pend_reg, cos_pend_reg;
  logic        mul_pend_next, add_pend_next, cos_pend_next;
  logic [31:0] x_reg, sq_reg, d_reg, t_reg, c_reg, h_reg, p_reg, out_data_reg;
  logic        in_wait, advance, timeout_hit;
  logic        mul_hit, add_hit, cos_hit;

  // in_ready comes from a register, so a pop never reaches it combinationally
  assign push     = in_valid && in_ready_reg;
  assign pop      = (state_reg == S_IDLE) && (count_reg != '0);
  assign in_ready = in_ready_reg;

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CNT_ONE;
    else if (!push && pop)
      count_next = count_reg - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg    <= count_next;
      in_ready_reg <= (count_next < DEPTH_CNT);
    end
  end

  assign in_wait = (state_reg >= S_1) && (state_reg <= S_5);
  assign mul_hit = mul_done && mul_pend_reg;
  assign add_hit = add_done && add_pend_reg;
  assign cos_hit = cos_done && cos_pend_reg;

  // Leave a wait state once every unit issued in it has reported back
  assign advance = in_wait && !first_reg
                   && !(mul_pend_reg && !mul_done)
                   && !(add_pend_reg && !add_done)
                   && !(cos_pend_reg && !cos_done);

  assign mul_start = first_reg && ((state_reg == S_1) || (state_reg == S_2) ||
                                   (state_reg == S_3) || (state_reg == S_4));
  assign add_start = first_reg && ((state_reg == S_1) || (state_reg == S_5));
  assign cos_start = first_reg && (state_reg == S_3);

  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    cos_arg = '0;
    case (state_reg)
      S_1: begin
        mul_a   = x_reg;
        mul_b   = x_reg;
        add_a   = x_reg;
        add_b   = OFFSET_C;
        add_sub = 1'b1;
      end
      S_2: begin
        mul_a = d_reg;
        mul_b = SCALE_K;
      end
      S_3: begin
        mul_a   = COEF_A;
        mul_b   = x_reg;
        cos_arg = t_reg;
      end
      S_4: begin
        mul_a = sq_reg;
        mul_b = c_reg;
      end
      S_5: begin
        add_a = h_reg;
        add_b = p_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    first_next    = 1'b0;
    mul_pend_next = first_reg ? mul_start : (mul_pend_reg && !mul_done);
    add_pend_next = first_reg ? add_start : (add_pend_reg && !add_done);
    cos_pend_next = first_reg ? cos_start : (cos_pend_reg && !cos_done);
    case (state_reg)
      S_IDLE: begin
        if (pop) begin
          state_next = S_1;
          first_next = 1'b1;
        end
      end
      S_1, S_2, S_3, S_4, S_5: begin
        if (advance) begin
          state_next = state_reg + 3'd1;
          first_next = (state_reg != S_5);
        end else if (timeout_hit) begin
          state_next    = S_OUT;
          mul_pend_next = 1'b0;
          add_pend_next = 1'b0;
          cos_pend_next = 1'b0;
        end
      end
      S_OUT: begin
        if (out_ready)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      first_reg    <= 1'b0;
      mul_pend_reg <= 1'b0;
      add_pend_reg <= 1'b0;
      cos_pend_reg <= 1'b0;
      x_reg        <= '0;
      sq_reg       <= '0;
      d_reg        <= '0;
      t_reg        <= '0;
      c_reg        <= '0;
      h_reg        <= '0;
      p_reg        <= '0;
      out_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      first_reg    <= first_next;
      mul_pend_reg <= mul_pend_next;
      add_pend_reg <= add_pend_next;
      cos_pend_reg <= cos_pend_next;
      if (pop)
        x_reg <= fifo_mem[rd_ptr_reg];
      if (mul_hit) begin
        case (state_reg)
          S_1:     sq_reg <= mul_result;
          S_2:     t_reg  <= mul_result;
          S_3:     h_reg  <= mul_result;
          S_4:     p_reg  <= mul_result;
          default: ;
        endcase
      end
      // The adder is only ever pending in S1 (difference) or S5 (final sum)
      if (add_hit) begin
        if (state_reg == S_1)
          d_reg <= add_result;
        else
          out_data_reg <= add_result;
      end
      if (cos_hit)
        c_reg <= cos_result;
      if (timeout_hit)
        out_data_reg <= QNAN;
    end
  end

`ifdef FP_EXPR_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            err_reg;

  assign timeout_hit = in_wait && !advance && (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_next != state_reg)
        wd_cnt_reg <= '0;
      else if (in_wait)
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      if (timeout_hit)
        err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign out_valid = (state_reg == S_OUT);
  assign out_data  = out_data_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule
